// File: rtl/mdu_sequencer_if.sv
// Operand/result bundle between the EX stage and the iterative multiply/divide unit.
// master: EX-stage side driving the request; slave: the multiply/divide sequencer.
interface mdu_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            START;
  logic [2:0]      FUNCT3;
  logic [XLEN-1:0] DATA1;
  logic [XLEN-1:0] DATA2;
  logic            FLUSH;
  logic            BUSY;
  logic            DONE;
  logic [XLEN-1:0] RESULT;

  modport master (
    output START, FUNCT3, DATA1, DATA2, FLUSH,
    input  BUSY, DONE, RESULT
  );

  modport slave (
    input  START, FUNCT3, DATA1, DATA2, FLUSH,
    output BUSY, DONE, RESULT
  );
endinterface

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on operand
// magnitudes, one radix-2 step per cycle, sign fix-up and special cases applied on entry to FIN.
// Optional macro MDU_EARLY_OUT_EN: trivial operations (zero multiply operand, zero divisor,
// signed overflow, unsigned dividend < divisor) skip the iteration and go straight to FIN.
module mdu_sequencer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic             CLK,
  input logic             RESET,
  mdu_sequencer_if.slave  bus
);

  localparam logic [XLEN-1:0] IntMin  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFin} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;

  // rs1 is treated as signed for MULH, MULHSU, DIV, REM
  function automatic logic a_is_signed(input logic [2:0] op);
    return (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
  endfunction

  // rs2 is treated as signed for MULH, DIV, REM
  function automatic logic b_is_signed(input logic [2:0] op);
    return (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  endfunction

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic s);
    return (s && v[XLEN-1]) ? -v : v;
  endfunction

  // Final result from the unsigned magnitude result in acc: {hi, lo} product, or
  // {remainder, quotient}. Division corner cases override whatever the iteration produced.
  function automatic logic [XLEN-1:0] fin_result(input logic [2:0]        op,
                                                 input logic [XLEN-1:0]   a,
                                                 input logic [XLEN-1:0]   b,
                                                 input logic [2*XLEN-1:0] acc);
    logic              sa, sb;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;
    sa   = a_is_signed(op) & a[XLEN-1];
    sb   = b_is_signed(op) & b[XLEN-1];
    prod = (sa ^ sb) ? -acc : acc;
    quo  = (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (!op[2]) begin
      return (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
    if (b == '0) begin
      return op[1] ? a : '1;
    end
    if (!op[0] && (a == IntMin) && (b == '1)) begin
      return op[1] ? '0 : IntMin;
    end
    return op[1] ? rem : quo;
  endfunction

  logic [XLEN-1:0]   ma, mb, ma_in, mb_in;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  logic [XLEN:0]     div_rem, div_diff;
  logic [2*XLEN-1:0] div_nxt;

  // One radix-2 step for each datapath, plus operand magnitudes for the acceptance edge
  always_comb begin
    ma       = magnitude(a_q, a_is_signed(op_q));
    mb       = magnitude(b_q, b_is_signed(op_q));
    ma_in    = magnitude(bus.DATA1, a_is_signed(bus.FUNCT3));
    mb_in    = magnitude(bus.DATA2, b_is_signed(bus.FUNCT3));
    // Multiplier sits in the low half and shifts out as the product shifts in from the top
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? ma : {XLEN{1'b0}})};
    mul_nxt  = {mul_sum, acc_q[XLEN-1:1]};
    // Partial remainder is below 2*divisor, so XLEN+1 bits hold it and the borrow is exact
    div_rem  = acc_q[2*XLEN-1:XLEN-1];
    div_diff = div_rem - {1'b0, mb};
    div_nxt  = div_diff[XLEN] ? {div_rem[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

`ifdef MDU_EARLY_OUT_EN
  logic early_in;

  // Operations whose result is known from the operands alone
  always_comb begin
    if (!bus.FUNCT3[2]) begin
      early_in = (bus.DATA1 == '0) || (bus.DATA2 == '0);
    end else begin
      early_in = (bus.DATA2 == '0)
              || (!bus.FUNCT3[0] && (bus.DATA1 == IntMin) && (bus.DATA2 == '1))
              || (bus.FUNCT3[0] && (bus.DATA1 < bus.DATA2));
    end
  end
`endif

  // Next-state logic: latch operands in IDLE, iterate, load RESULT only on entry to FIN
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (bus.START) begin
          op_d    = bus.FUNCT3;
          a_d     = bus.DATA1;
          b_d     = bus.DATA2;
          cnt_d   = '0;
          acc_d   = bus.FUNCT3[2] ? {{XLEN{1'b0}}, ma_in} : {{XLEN{1'b0}}, mb_in};
          state_d = bus.FUNCT3[2] ? StDiv : StMul;
`ifdef MDU_EARLY_OUT_EN
          if (early_in) begin
            // {DATA1, 0} reads as quotient 0 / remainder DATA1; a zero product reads as 0
            state_d  = StFin;
            result_d = fin_result(bus.FUNCT3, bus.DATA1, bus.DATA2,
                                  bus.FUNCT3[2] ? {bus.DATA1, {XLEN{1'b0}}} : '0);
          end
`endif
        end
      end
      StMul: begin
        acc_d = mul_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CntLast) begin
          state_d  = StFin;
          cnt_d    = '0;
          result_d = fin_result(op_q, a_q, b_q, mul_nxt);
        end
      end
      StDiv: begin
        acc_d = div_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CntLast) begin
          state_d  = StFin;
          cnt_d    = '0;
          result_d = fin_result(op_q, a_q, b_q, div_nxt);
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // Abort beats everything, including a same-edge START or the final step
    if (bus.FLUSH) begin
      state_d  = StIdle;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign bus.BUSY   = (state_q != StIdle);
  assign bus.DONE   = (state_q == StFin);
  assign bus.RESULT = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: results, latency, BUSY span, FLUSH, async reset.
module tb_mdu_sequencer;

`ifdef MDU_EARLY_OUT_EN
  localparam bit EarlyOn = 1'b1;
`else
  localparam bit EarlyOn = 1'b0;
`endif

  logic CLK;
  logic RESET;
  int   n_checks;
  int   n_fail;
  logic [31:0] last_res;

  mdu_sequencer_if #(.XLEN(32)) bus ();

  mdu_sequencer #(
    .XLEN  (32),
    .CNT_W (6)
  ) u_dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; issues START immediately and returns at the negedge of the
  // first IDLE cycle after DONE, so consecutive calls are back-to-back.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit early,
                        input bit poke);
    int lat;
    int busy_n;
    int exp_lat;
    lat     = 0;
    busy_n  = 0;
    exp_lat = (early && EarlyOn) ? 1 : 33;
    bus.START  = 1'b1;
    bus.FUNCT3 = f3;
    bus.DATA1  = a;
    bus.DATA2  = b;
    @(negedge CLK);
    // Scramble inputs so a design that re-samples them would produce a wrong result
    bus.START  = 1'b0;
    bus.FUNCT3 = ~f3;
    bus.DATA1  = ~a;
    bus.DATA2  = ~b;
    for (int i = 1; i <= 40; i++) begin
      bus.START = poke && (i == 3);
      if (bus.BUSY) busy_n++;
      if (bus.DONE) begin
        lat = i;
        break;
      end
      @(negedge CLK);
    end
    bus.START = 1'b0;
    check_eq({tag, " result"}, bus.RESULT, exp);
    check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, " busy cycles"}, 32'(busy_n), 32'(exp_lat));
    @(negedge CLK);
    check_eq({tag, " done drop"}, 32'(bus.DONE), 32'd0);
    check_eq({tag, " busy drop"}, 32'(bus.BUSY), 32'd0);
    last_res = exp;
  endtask

  int done_n;

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    last_res   = 32'h0;
    RESET      = 1'b0;
    bus.START  = 1'b0;
    bus.FUNCT3 = 3'b000;
    bus.DATA1  = 32'h0;
    bus.DATA2  = 32'h0;
    bus.FLUSH  = 1'b0;
    #2;
    check_eq("reset busy", 32'(bus.BUSY), 32'd0);
    check_eq("reset done", 32'(bus.DONE), 32'd0);
    check_eq("reset result", bus.RESULT, 32'h0);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);

    // Multiplies
    run_op("mul 7x-3",        3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 1'b0);
    run_op("mulh min*min",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 1'b0);
    run_op("mulhu 2^31*2^31", 3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 1'b0);
    run_op("mulhsu -1*ffff",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    run_op("mulhu ffff*ffff", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0);
    run_op("mul -1*-1",       3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    run_op("mulh -1*-1",      3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0);
    run_op("mulh 2^30*4",     3'b001, 32'h40000000, 32'h00000004, 32'h00000001, 1'b0, 1'b0);
    run_op("mul 0x5",         3'b000, 32'h00000000, 32'h00000005, 32'h00000000, 1'b1, 1'b0);
    // Divides
    run_op("div -7/2",        3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 1'b0);
    run_op("rem -7/2",        3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b0);
    run_op("div 7/-2",        3'b100, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 1'b0);
    run_op("rem 7/-2",        3'b110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
    run_op("divu 100/7",      3'b101, 32'd100,      32'd7,        32'd14,       1'b0, 1'b0);
    run_op("remu 100/7",      3'b111, 32'd100,      32'd7,        32'd2,        1'b0, 1'b0);
    run_op("divu ffff/1",     3'b101, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0);
    run_op("div x/0",         3'b100, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_op("rem x/0",         3'b110, 32'h12345678, 32'h00000000, 32'h12345678, 1'b1, 1'b0);
    run_op("divu x/0",        3'b101, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_op("div ovf",         3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0);
    run_op("rem ovf",         3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
    run_op("divu 3/10",       3'b101, 32'd3,        32'd10,       32'd0,        1'b1, 1'b0);
    run_op("remu 3/10",       3'b111, 32'd3,        32'd10,       32'd3,        1'b1, 1'b0);
    // START pulsed while busy must not disturb the in-flight multiply
    run_op("mul busy-start",  3'b000, 32'h00000003, 32'h40000000, 32'hC0000000, 1'b0, 1'b1);

    // FLUSH at iteration 10 of a DIVU
    bus.START  = 1'b1;
    bus.FUNCT3 = 3'b101;
    bus.DATA1  = 32'd100;
    bus.DATA2  = 32'd7;
    @(negedge CLK);
    bus.START = 1'b0;
    repeat (9) @(negedge CLK);
    bus.FLUSH = 1'b1;
    @(negedge CLK);
    bus.FLUSH = 1'b0;
    check_eq("flush busy", 32'(bus.BUSY), 32'd0);
    check_eq("flush done", 32'(bus.DONE), 32'd0);
    check_eq("flush result", bus.RESULT, last_res);
    run_op("divu after flush", 3'b101, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);

    // FLUSH and START on the same IDLE edge: START dropped
    bus.START  = 1'b1;
    bus.FLUSH  = 1'b1;
    bus.FUNCT3 = 3'b000;
    bus.DATA1  = 32'd7;
    bus.DATA2  = 32'd3;
    @(negedge CLK);
    bus.START = 1'b0;
    bus.FLUSH = 1'b0;
    check_eq("flush+start busy", 32'(bus.BUSY), 32'd0);
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.DONE) done_n++;
      @(negedge CLK);
    end
    check_eq("flush+start no done", 32'(done_n), 32'd0);
    check_eq("flush+start result", bus.RESULT, last_res);

    // Async reset at iteration 5 of a MUL
    bus.START  = 1'b1;
    bus.FUNCT3 = 3'b000;
    bus.DATA1  = 32'h00000007;
    bus.DATA2  = 32'hFFFFFFFD;
    @(negedge CLK);
    bus.START = 1'b0;
    repeat (4) @(negedge CLK);
    #1 RESET = 1'b0;
    #1;
    check_eq("async rst busy", 32'(bus.BUSY), 32'd0);
    check_eq("async rst done", 32'(bus.DONE), 32'd0);
    check_eq("async rst result", bus.RESULT, 32'h0);
    @(negedge CLK);
    RESET = 1'b1;
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.DONE) done_n++;
      @(negedge CLK);
    end
    check_eq("post rst no done", 32'(done_n), 32'd0);
    run_op("mul after reset", 3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
